// File: rtl/fb_scanout.sv
// fb_scanout: frame buffer scan-out stage between the GPU frame buffer RAM and
// the VGA pins. Maps the VGA row/column onto the Game Boy window, fetches the
// 16-bit word holding 8 two-bit pixels, and drives grey-scale RGB with a
// border colour. Syncs are delayed to stay aligned with the pixel pipeline.
//
// Optional feature macro: FB_SCANOUT_SCALE2X_EN
//   defined   -> 2x scaling, 320x288 window, each Game Boy pixel is doubled
//   undefined -> 1:1 mapping on a 160x144 window
module fb_scanout #(
  parameter int unsigned H_OFFSET = 0,
  parameter int unsigned V_OFFSET = 0,
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned V_ACTIVE = 144,
  parameter logic [3:0]  BORDER   = 4'h7
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iRow,
  input  logic [15:0] iCol,
  input  logic        iActive,
  input  logic        iHsync,
  input  logic        iVsync,
  output logic [12:0] oFbReadAddr,
  output logic        oFbReadEn,
  input  logic [15:0] iFbReadData,
  output logic [3:0]  oVgaRed,
  output logic [3:0]  oVgaGreen,
  output logic [3:0]  oVgaBlue,
  output logic        oHsync,
  output logic        oVsync,
  output logic        oFrameStart,
  output logic [7:0]  oFrameCount
);

`ifdef FB_SCANOUT_SCALE2X_EN
  localparam int unsigned SCALE = 2;
  localparam int unsigned SHIFT = 1;
`else
  localparam int unsigned SCALE = 1;
  localparam int unsigned SHIFT = 0;
`endif

  localparam logic [15:0] H_OFF = 16'(H_OFFSET);
  localparam logic [15:0] V_OFF = 16'(V_OFFSET);
  localparam logic [15:0] H_LEN = 16'(H_ACTIVE * SCALE);
  localparam logic [15:0] V_LEN = 16'(V_ACTIVE * SCALE);

  // Stage-0 combinational signals
  logic [15:0] rel_col;
  logic [15:0] rel_row;
  logic [15:0] gb_col;
  logic [15:0] gb_row;
  logic        in_win;
  logic        first_pix;
  logic [12:0] next_addr;
  logic        need_read;

  // Stage-1 pipeline registers
  logic        s1_in_win;
  logic        s1_active;
  logic [2:0]  s1_pix;
  logic        s1_hsync;
  logic        s1_vsync;
  logic        s1_first;

  // Stage-2 word handling and colour
  logic [15:0] held_word;
  logic [15:0] word_now;
  logic [1:0]  shade;
  logic [3:0]  grey;
  logic [3:0]  colour;

  // Window test, Game Boy coordinates and fetch decision for the sampled position
  always_comb begin
    // A position below the offset wraps to a huge unsigned value, so a single
    // upper-bound compare also rejects the region before the window.
    rel_col   = iCol - H_OFF;
    rel_row   = iRow - V_OFF;
    in_win    = iActive && (rel_col < H_LEN) && (rel_row < V_LEN);
    gb_col    = rel_col >> SHIFT;
    gb_row    = rel_row >> SHIFT;
    next_addr = 13'((gb_row << 5) + (gb_col >> 3));
    first_pix = in_win && (rel_col == 16'd0) && (rel_row == 16'd0);
    // A fresh read is forced whenever the previous cycle was outside the
    // window (line start, after reset, after iActive dropped).
    need_read = in_win && ((next_addr != oFbReadAddr) || !s1_in_win);
  end

  // Stage 0: register the position info and issue the frame buffer read
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      oFbReadAddr <= 13'd0;
      oFbReadEn   <= 1'b0;
      s1_in_win   <= 1'b0;
      s1_active   <= 1'b0;
      s1_pix      <= 3'd0;
      s1_hsync    <= 1'b1;
      s1_vsync    <= 1'b1;
      s1_first    <= 1'b0;
    end else begin
      oFbReadEn <= need_read;
      if (need_read) begin
        oFbReadAddr <= next_addr;
      end
      s1_in_win <= in_win;
      s1_active <= iActive;
      s1_pix    <= gb_col[2:0];
      s1_hsync  <= iHsync;
      s1_vsync  <= iVsync;
      s1_first  <= first_pix;
    end
  end

  // RAM data is used directly on a read cycle, otherwise the held word is reused
  assign word_now = oFbReadEn ? iFbReadData : held_word;

  // Select the 2-bit pixel; pixel 0 sits in the top two bits of the word
  always_comb begin
    shade = 2'd0;
    case (s1_pix)
      3'd0: shade = word_now[15:14];
      3'd1: shade = word_now[13:12];
      3'd2: shade = word_now[11:10];
      3'd3: shade = word_now[9:8];
      3'd4: shade = word_now[7:6];
      3'd5: shade = word_now[5:4];
      3'd6: shade = word_now[3:2];
      3'd7: shade = word_now[1:0];
      default: shade = 2'd0;
    endcase
  end

  // Map shade to grey level and apply blanking / border priority
  always_comb begin
    grey = 4'h0;
    case (shade)
      2'd0: grey = 4'hF;
      2'd1: grey = 4'hA;
      2'd2: grey = 4'h5;
      2'd3: grey = 4'h0;
      default: grey = 4'h0;
    endcase
    if (!s1_active) begin
      colour = 4'h0;
    end else if (!s1_in_win) begin
      colour = BORDER;
    end else begin
      colour = grey;
    end
  end

  // Stage 1/2: capture the returned word and register colour, syncs and frame tracking
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      held_word   <= 16'd0;
      oVgaRed     <= 4'h0;
      oVgaGreen   <= 4'h0;
      oVgaBlue    <= 4'h0;
      oHsync      <= 1'b1;
      oVsync      <= 1'b1;
      oFrameStart <= 1'b0;
      oFrameCount <= 8'd0;
    end else begin
      if (oFbReadEn) begin
        held_word <= iFbReadData;
      end
      oVgaRed     <= colour;
      oVgaGreen   <= colour;
      oVgaBlue    <= colour;
      oHsync      <= s1_hsync;
      oVsync      <= s1_vsync;
      oFrameStart <= s1_first;
      if (s1_first) begin
        oFrameCount <= oFrameCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed self-checking bench for fb_scanout.
// The frame buffer model returns memory contents only while the read strobe
// is high and a poison value otherwise, so any wrongly reused word shows up.
module tb_fb_scanout;

  logic        iClock = 1'b0;
  logic        iReset = 1'b0;
  logic [15:0] iRow = 16'd0;
  logic [15:0] iCol = 16'd0;
  logic        iActive = 1'b0;
  logic        iHsync = 1'b1;
  logic        iVsync = 1'b1;
  logic [12:0] oFbReadAddr;
  logic        oFbReadEn;
  logic [15:0] iFbReadData;
  logic [3:0]  oVgaRed;
  logic [3:0]  oVgaGreen;
  logic [3:0]  oVgaBlue;
  logic        oHsync;
  logic        oVsync;
  logic        oFrameStart;
  logic [7:0]  oFrameCount;

  logic [15:0] mem [0:8191];
  int tests = 0;
  int fails = 0;
  int reads;
  int expCount;
  logic [3:0] scanExp [8];

  fb_scanout dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iRow        (iRow),
    .iCol        (iCol),
    .iActive     (iActive),
    .iHsync      (iHsync),
    .iVsync      (iVsync),
    .oFbReadAddr (oFbReadAddr),
    .oFbReadEn   (oFbReadEn),
    .iFbReadData (iFbReadData),
    .oVgaRed     (oVgaRed),
    .oVgaGreen   (oVgaGreen),
    .oVgaBlue    (oVgaBlue),
    .oHsync      (oHsync),
    .oVsync      (oVsync),
    .oFrameStart (oFrameStart),
    .oFrameCount (oFrameCount)
  );

  always #5 iClock = ~iClock;

  assign iFbReadData = oFbReadEn ? mem[oFbReadAddr] : 16'hDEAD;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkColour(input string tag, input logic [3:0] expected);
    checkOutput(tag, {20'd0, oVgaRed, oVgaGreen, oVgaBlue}, {20'd0, expected, expected, expected});
  endtask

  task automatic applyStimulus(input logic [15:0] row, input logic [15:0] col,
                               input logic act, input logic hs, input logic vs);
    iRow    = row;
    iCol    = col;
    iActive = act;
    iHsync  = hs;
    iVsync  = vs;
    @(posedge iClock);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[0]   = 16'h1B1B;
    mem[1]   = 16'hFFFF;
    mem[32]  = 16'h5555;
    mem[96]  = 16'h00C0;
    mem[162] = 16'h2000;
    scanExp  = '{4'hF, 4'hA, 4'h5, 4'h0, 4'hF, 4'hA, 4'h5, 4'h0};
    expCount = 0;

    // Reset held with active inputs
    iReset = 1'b0;
    repeat (3) applyStimulus(16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    checkColour("reset_rgb", 4'h0);
    checkOutput("reset_hsync", oHsync, 1);
    checkOutput("reset_vsync", oVsync, 1);
    checkOutput("reset_en", oFbReadEn, 0);
    checkOutput("reset_addr", oFbReadAddr, 0);
    checkOutput("reset_fstart", oFrameStart, 0);
    checkOutput("reset_fcount", oFrameCount, 0);
    iReset = 1'b1;

`ifdef FB_SCANOUT_SCALE2X_EN
    // Scaled window: row 1 is still Game Boy row 0, 16 columns share one word
    applyStimulus(16'd400, 16'd0, 1'b0, 1'b1, 1'b1);
    reads = 0;
    for (int c = 0; c <= 16; c++) begin
      applyStimulus(16'd1, 16'(c), 1'b1, 1'b1, 1'b1);
      if (c < 16) reads += int'(oFbReadEn);
      if (c == 0) checkOutput("s2_addr0", oFbReadAddr, 0);
      if (c > 0) checkColour("s2_pixel", scanExp[(c - 1) / 2]);
    end
    checkOutput("s2_reads", reads, 1);
    applyStimulus(16'd2, 16'd0, 1'b1, 1'b1, 1'b1);
    checkOutput("s2_row2_en", oFbReadEn, 1);
    checkOutput("s2_row2_addr", oFbReadAddr, 32);
    applyStimulus(16'd2, 16'd1, 1'b1, 1'b1, 1'b1);
    checkColour("s2_row2_pix", 4'hA);
`else
    // Row 0, columns 0..7 from word 16'h1B1B, then column 8 starts word 1
    reads = 0;
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(16'd0, 16'(c), 1'b1, c[0], c == 0);
      if (c < 8) reads += int'(oFbReadEn);
      if (c == 0) begin
        checkOutput("scan_en0", oFbReadEn, 1);
        checkOutput("scan_addr0", oFbReadAddr, 0);
      end
      if (c > 0) begin
        checkColour("scan_pixel", scanExp[c - 1]);
        checkOutput("scan_hsync", oHsync, (c - 1) % 2);
        checkOutput("scan_vsync", oVsync, c == 1);
      end
      if (c == 1) begin
        expCount++;
        checkOutput("scan_fstart", oFrameStart, 1);
        checkOutput("scan_fcount", oFrameCount, 8'(expCount));
      end
      if (c == 2) checkOutput("scan_fstart_off", oFrameStart, 0);
    end
    checkOutput("scan_reads", reads, 1);
    checkOutput("scan_addr8", oFbReadAddr, 1);

    // Address arithmetic, border colour and blanking
    applyStimulus(16'd5, 16'd17, 1'b1, 1'b0, 1'b0);
    checkOutput("addr_162", oFbReadAddr, 162);
    checkOutput("addr_162_en", oFbReadEn, 1);
    applyStimulus(16'd5, 16'd160, 1'b1, 1'b1, 1'b0);
    checkOutput("border_en", oFbReadEn, 0);
    checkColour("pix_162", 4'h5);
    applyStimulus(16'd5, 16'd18, 1'b0, 1'b1, 1'b0);
    checkColour("border_rgb", 4'h7);
    applyStimulus(16'd5, 16'd19, 1'b0, 1'b1, 1'b0);
    checkColour("blank_rgb", 4'h0);

    // Reset pulsed mid-line: col 4 must come from a fresh read
    applyStimulus(16'd3, 16'd2, 1'b1, 1'b1, 1'b1);
    iReset = 1'b0;
    applyStimulus(16'd3, 16'd3, 1'b1, 1'b1, 1'b1);
    checkColour("midrst_rgb", 4'h0);
    checkOutput("midrst_hsync", oHsync, 1);
    iReset = 1'b1;
    applyStimulus(16'd3, 16'd4, 1'b1, 1'b0, 1'b1);
    checkOutput("midrst_en", oFbReadEn, 1);
    checkOutput("midrst_addr", oFbReadAddr, 96);
    applyStimulus(16'd3, 16'd5, 1'b1, 1'b1, 1'b1);
    checkColour("midrst_pix4", 4'h0);
    checkOutput("midrst_hsync_al", oHsync, 0);
    checkOutput("reuse_en", oFbReadEn, 0);
    applyStimulus(16'd3, 16'd6, 1'b1, 1'b1, 1'b1);
    checkColour("reuse_pix5", 4'hF);
    checkOutput("midrst_fcount", oFrameCount, 0);
    expCount = 0;
`endif

    // Frame start pulses and counter wrap
    applyStimulus(16'd300, 16'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'd0, 16'd1, 1'b1, 1'b1, 1'b1);
    expCount++;
    checkOutput("frame_start", oFrameStart, 1);
    checkOutput("frame_count", oFrameCount, 8'(expCount));
    applyStimulus(16'd0, 16'd2, 1'b1, 1'b1, 1'b1);
    checkOutput("frame_start_one", oFrameStart, 0);
    applyStimulus(16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'd0, 16'd1, 1'b1, 1'b1, 1'b1);
    expCount++;
    checkOutput("frame_count2", oFrameCount, 8'(expCount));
    while (expCount < 256) begin
      applyStimulus(16'd0, 16'd0, 1'b1, 1'b1, 1'b1);
      applyStimulus(16'd0, 16'd1, 1'b1, 1'b1, 1'b1);
      expCount++;
      if (expCount == 255) checkOutput("frame_count255", oFrameCount, 255);
    end
    checkOutput("frame_wrap_start", oFrameStart, 1);
    checkOutput("frame_wrap", oFrameCount, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Pixel scan-out stage between the GPU frame buffer RAM and the VGA pins. Takes the row/column position and sync signals from the VGA controller, and computes the frame buffer read address. It then extracts the 2-bit Game Boy pixel from the returned 16-bit word and drives grey-scale RGB with a border colour. Sync signals are delayed to stay aligned with pixel data. It replaces the open-coded address/mux/colour logic at the top level, which feeds the frame buffer read port directly.

## Interface
- H_OFFSET, 0: first VGA column of the Game Boy window.
- V_OFFSET, 0: first VGA row of the Game Boy window.
- H_ACTIVE, 160: Game Boy pixels per line.
- V_ACTIVE, 144: Game Boy lines per frame.
- BORDER, 4'h7: value driven on all three channels outside the window while iActive is high.
---
- iClock  in  1  system clock, single clock domain.
- iReset  in  1  reset: synchronous, active-low.
- iRow  in  16  VGA row from controller.
- iCol  in  16  VGA column from controller.
- iActive  in  1  VGA display-enable.
- iHsync, iVsync  in  1 each  raw syncs from controller.
- oFbReadAddr  out  13  frame buffer word address.
- oFbReadEn  out  1  read strobe.
- iFbReadData  in  16  RAM data, valid exactly 1 cycle after the address.
- oVgaRed, oVgaGreen, oVgaBlue  out  4 each  pixel colour.
- oHsync, oVsync  out  1 each  syncs delayed by 2 cycles.
- oFrameStart  out  1  one-cycle pulse when pixel (0,0) of the window is presented.
- oFrameCount  out  8  frames presented, wraps 255->0.

## Operation
- Scale factor S: 2 with the scaling macro, else 1 (see Configuration).
- Window test (stage 0):
  - inWin = iActive && iCol in [H_OFFSET, H_OFFSET+H_ACTIVE*S) && iRow in [V_OFFSET, V_OFFSET+V_ACTIVE*S).
  - Compare against 16-bit unsigned values.
  - The region below an offset is outside the window.
- Coordinates:
  - gbCol = (iCol-H_OFFSET)/S.
  - gbRow = (iRow-V_OFFSET)/S.
- Address: oFbReadAddr = gbRow*32 + gbCol[7:3], truncated to 13 bits. Row stride is 32 words; 8 pixels per word.
- Pixel order within a word: pixel k = gbCol[2:0] occupies bits [15-2k:14-2k]; pixel 0 is [15:14].
- Fetch reuse:
  - oFbReadEn=1 only when inWin and either the address differs from the last issued address or the previous cycle was not inWin.
  - Otherwise the held word is reused.
  - Outside the window, oFbReadEn=0 and the address holds its last value.
- Word register: loads iFbReadData in stage 1 when the stage-0 read flag was set; otherwise it keeps its value.
- Colour map, shade to channel value, same on R=G=B:
  - 0 -> 4'hF
  - 1 -> 4'hA
  - 2 -> 4'h5
  - 3 -> 4'h0
- Output priority (stage 2): not iActive -> 4'h0; else not inWin -> BORDER; else mapped shade.
- oFrameStart: asserted in the stage-2 cycle presenting gbRow=0, gbCol=0 with inWin. With S=2 it pulses only on the first of the duplicated cycles, i.e. iRow==V_OFFSET && iCol==H_OFFSET.
- oFrameCount increments on the same cycle as oFrameStart.

## Timing
- Pipeline: stage 0 registers inputs and issues the read; stage 1 is RAM return and word capture; stage 2 is pixel select, colour and output registers.
- Latency from iRow/iCol/iActive/iHsync/iVsync to RGB/oHsync/oVsync is exactly 2 cycles, fixed regardless of reuse.
- oFbReadAddr/oFbReadEn are registered: asserted the cycle after iCol is sampled. RAM data is consumed the following cycle.
- Reset (iReset==0 at a clock edge):
  - RGB=0, oHsync=1, oVsync=1, oFbReadEn=0, oFbReadAddr=0, oFrameStart=0, oFrameCount=0.
  - Held word, last-address register and all pipeline valids are cleared.
- Reset mid-line: the first cycle after release is treated as "previous not inWin", so a fresh read is forced and no stale word is shown.
- Line wrap: leaving the window clears the reuse state. The first window pixel of every line always reads.
- iActive dropping mid-window forces black 2 cycles later and ends reuse.

## Configuration
- FB_SCANOUT_SCALE2X_EN:
  - Defined: S=2, giving a 320x288 window. Each Game Boy pixel is repeated on 2 columns and 2 rows, and a word is read once per 16 VGA columns.
  - Undefined: S=1, 1:1 mapping on a 160x144 window.

## Test plan
- Reset held 3 cycles with active inputs -> all outputs at reset values; oHsync=oVsync=1; oFrameCount=0.
- Memory word 0 = 16'h1B1B, offsets 0, S=1, scan row 0, cols 0..7 -> shades 0,1,2,3,0,1,2,3 -> RGB F,A,5,0,F,A,5,0. Output 2 cycles after each column; exactly one oFbReadEn.
- Row 5, col 17 -> oFbReadAddr=13'd162; col 160 with iActive=1 -> RGB=4'h7; iActive=0 -> 4'h0.
- FB_SCANOUT_SCALE2X_EN, cols 0..15 of row 1 -> address 0, each pixel shown twice, one read strobe; row 2 -> address 32.
- Two full frames -> two oFrameStart pulses, oFrameCount=2. Preload oFrameCount path through 256 frames -> wraps to 0.
- Reset pulsed at col 3 of a line, released at col 4 -> col 4 output reflects a freshly read word; syncs still 2-cycle aligned.
